// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - digit-serial magnitude comparator with ready/valid handshakes
//
// Compares two WIDTH-bit operands DIGIT bits per cycle, most-significant digit
// first, stopping at the first differing digit.
//
// Parameters:
//   WIDTH  - operand width in bits (>= 2)
//   DIGIT  - bits compared per cycle (>= 1, divides WIDTH)
//   SIGNED - 0: unsigned compare, 1: two's-complement compare
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake; A/B sampled on accept only
//   A, B                - operands
//   out_valid, out_ready- result handshake; result held under backpressure
//   A_greater_B, A_equal_B, A_lesser_B - registered one-hot result flags
//   digits_used         - registered count of digits examined for the result
module seq_magnitude_comparator #(
  parameter int WIDTH  = 32,
  parameter int DIGIT  = 4,
  parameter int SIGNED = 0,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int CW    = $clog2(NDIG) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A_greater_B,
  output logic             A_equal_B,
  output logic             A_lesser_B,
  output logic [CW-1:0]    digits_used
);

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_magnitude_comparator: WIDTH must be >= 2");
  end
  if (DIGIT < 1) begin : g_bad_digit
    $error("seq_magnitude_comparator: DIGIT must be >= 1");
  end else if (WIDTH % DIGIT != 0) begin : g_bad_div
    $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
  end

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    count;
  logic [CW-1:0]    cnt_next;
  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_ne;
  logic             last_dig;

  assign dig_a    = a_sh[WIDTH-1 -: DIGIT];
  assign dig_b    = b_sh[WIDTH-1 -: DIGIT];
  assign dig_ne   = (dig_a != dig_b);
  assign cnt_next = count + 1'b1;
  assign last_dig = (cnt_next == CW'(NDIG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = CMP;
      end
      CMP: begin
        if (dig_ne || last_dig) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      count       <= '0;
      A_greater_B <= 1'b0;
      A_equal_B   <= 1'b0;
      A_lesser_B  <= 1'b0;
      digits_used <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= A ^ FLIP;
            b_sh  <= B ^ FLIP;
            count <= '0;
          end
        end
        CMP: begin
          count <= cnt_next;
          if (dig_ne) begin
            // First differing digit decides the whole compare.
            A_greater_B <= (dig_a > dig_b);
            A_lesser_B  <= (dig_a < dig_b);
            A_equal_B   <= 1'b0;
            digits_used <= cnt_next;
          end else if (last_dig) begin
            A_greater_B <= 1'b0;
            A_lesser_B  <= 1'b0;
            A_equal_B   <= 1'b1;
            digits_used <= cnt_next;
          end else begin
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - self-checking bench for seq_magnitude_comparator
module tb_seq_magnitude_comparator;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B;
  logic        A_greater_B, A_equal_B, A_lesser_B;
  logic [3:0]  digits_used;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_A, s_B;
  logic        s_gt, s_eq, s_lt;
  logic [3:0]  s_du;

  int total = 0;
  int bad   = 0;
  int ndone = 0;
  int nexp  = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(32), .DIGIT(4), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .A_greater_B(A_greater_B), .A_equal_B(A_equal_B), .A_lesser_B(A_lesser_B),
    .digits_used(digits_used)
  );

  seq_magnitude_comparator #(.WIDTH(32), .DIGIT(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .A(s_A), .B(s_B), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .A_greater_B(s_gt), .A_equal_B(s_eq), .A_lesser_B(s_lt),
    .digits_used(s_du)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer ordering plus the position of the highest
  // differing bit decides which digit terminates the compare.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input bit sgn, output logic [2:0] f, output int du);
    logic [31:0] x;
    if (sgn) f = ($signed(a) > $signed(b)) ? GT : ($signed(a) == $signed(b)) ? EQ : LT;
    else     f = (a > b) ? GT : (a == b) ? EQ : LT;
    x  = a ^ b;
    du = 8;
    for (int i = 0; i < 32; i++) if (x[i]) du = (31 - i) / 4 + 1;
  endfunction

  typedef struct { logic [2:0] f; int du; } lit_t;
  lit_t lit_q[$];

  bit         busy = 0;
  int         age  = 0;
  logic [2:0] mf, lf;
  int         mdu, ldu;
  bit         has_lit;

  always @(negedge clk) begin
    bit   was_busy;
    bit   exp_ov;
    lit_t l;
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_flags", {A_greater_B, A_equal_B, A_lesser_B}, 0);
      chk("rst_digits_used", digits_used, 0);
      chk("rst_s_out_valid", s_out_valid, 0);
      busy = 0;
      lit_q.delete();
    end else begin
      was_busy = busy;
      exp_ov   = busy && (age >= mdu);
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("flags", {A_greater_B, A_equal_B, A_lesser_B}, mf);
        chk("digits_used", digits_used, mdu);
      end
      if (exp_ov && out_ready) begin
        if (has_lit) begin
          chk("lit_flags", {A_greater_B, A_equal_B, A_lesser_B}, lf);
          chk("lit_digits_used", digits_used, ldu);
        end
        busy = 0;
        ndone++;
      end else if (busy) begin
        age++;
      end
      if (!was_busy && in_valid) begin
        model(A, B, 1'b0, mf, mdu);
        busy = 1;
        age  = 0;
        if (lit_q.size() > 0) begin
          l = lit_q.pop_front();
          lf = l.f; ldu = l.du; has_lit = 1;
        end else begin
          has_lit = 0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f, input int du, input bit hold, input bit counted);
    bit ok;
    lit_t l;
    l.f = f; l.du = du;
    lit_q.push_back(l);
    if (counted) nexp++;
    A = a; B = b; in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      ok = !busy;
    end
    #1;
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic send_s(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input int du);
    logic [2:0] ef;
    int         edu;
    int         lat;
    model(a, b, 1'b1, ef, edu);
    chk("s_in_ready", s_in_ready, 1);
    s_A = a; s_B = b; s_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (s_out_valid) break;
    end
    chk("s_out_valid", s_out_valid, 1);
    chk("s_latency", lat, edu);
    chk("s_flags", {s_gt, s_eq, s_lt}, ef);
    chk("s_digits_used", s_du, edu);
    chk("s_lit_flags", {s_gt, s_eq, s_lt}, f);
    chk("s_lit_digits_used", s_du, du);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_A = '0; s_B = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(32'h8000_0000, 32'h7FFF_FFFF, GT, 1, 0, 1); wait_idle();
    send(32'h1234_5678, 32'h1234_5678, EQ, 8, 0, 1); wait_idle();
    send(32'hFFFF_FFFF, 32'h0000_0001, GT, 1, 0, 1); wait_idle();
    send(32'h0000_0001, 32'hFFFF_FFFF, LT, 1, 0, 1); wait_idle();
    send(32'h1230_0000, 32'h1240_0000, LT, 3, 0, 1); wait_idle();

    out_ready = 1'b0;
    send(32'h1234_5670, 32'h1234_5679, LT, 8, 0, 1);
    repeat (8) @(posedge clk);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    send(32'hAAAA_AAAA, 32'hAAAA_AAAA, EQ, 8, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(32'd5, 32'd3, GT, 8, 0, 1); wait_idle();

    send(32'h0000_0001, 32'h0000_0002, LT, 8, 1, 1);
    send(32'hF000_0000, 32'h1000_0000, GT, 1, 1, 1);
    send(32'h0000_0007, 32'h0000_0007, EQ, 8, 1, 1);
    send(32'h0050_0000, 32'h0040_0000, GT, 3, 0, 1);
    wait_idle();

    send_s(32'hFFFF_FFFF, 32'h0000_0001, LT, 1);
    send_s(32'hFFFF_FFFB, 32'hFFFF_FFFD, LT, 8);
    send_s(32'h8000_0000, 32'h7FFF_FFFF, LT, 1);
    send_s(32'h7FFF_FFFF, 32'h8000_0000, GT, 1);
    send_s(32'h0000_0000, 32'h0000_0000, EQ, 8);

    chk("results_presented", ndone, nexp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand width in bits, legal when WIDTH >= 2.
REQ-002 The block SHALL have parameter DIGIT, default 4: bits compared per cycle, legal when DIGIT >= 1 and WIDTH % DIGIT == 0; NDIG = WIDTH/DIGIT.
REQ-003 The block SHALL have parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state rises on the posedge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: operands A and B are offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-009 The block SHALL have ports A and B, inputs, WIDTH bits each: the operands, sampled only on input handshake.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have ports A_greater_B, A_equal_B and A_lesser_B, outputs, 1 bit each: result flags, registered.
REQ-013 The block SHALL have port digits_used, output, $clog2(NDIG)+1 bits: number of digits examined for the presented result, registered.
REQ-014 The block SHALL NOT instantiate any generic or combinational compare of the full WIDTH; only DIGIT-wide compares are used.
REQ-015 The block SHALL flag illegal parameters with an elaboration-time error.

Function
REQ-016 The block SHALL implement FSM states IDLE, CMP and DONE.
REQ-017 The block SHALL drive in_ready = 1 only in IDLE.
REQ-018 The block SHALL drive out_valid = 1 only in DONE.
REQ-019 When in_valid && in_ready, the block SHALL capture A and B into internal shift registers, clear the digit counter and enter CMP.
REQ-020 When SIGNED = 1, the block SHALL invert the MSB of both captured operands (offset-binary), then perform an unsigned compare.
REQ-021 In CMP, each cycle, the block SHALL compare the most-significant DIGIT bits of both shift registers and increment the digit counter.
REQ-022 If the compared digits differ, the block SHALL register the result (greater or lesser), load digits_used = count and enter DONE (early termination).
REQ-023 If the compared digits are equal and this is digit NDIG, the block SHALL register A_equal_B = 1, load digits_used = NDIG and enter DONE.
REQ-024 If the compared digits are equal and this is not digit NDIG, the block SHALL shift both registers left by DIGIT and remain in CMP.
REQ-025 Latency SHALL be: accept on edge 0, out_valid high after edge j, where j = digits_used, range 1..NDIG.
REQ-026 When out_valid = 1, the block SHALL assert exactly one of the three flags.
REQ-027 While out_valid && !out_ready, the block SHALL hold the flags and digits_used stable and keep in_ready = 0 (backpressure).
REQ-028 On out_valid && out_ready, the block SHALL return to IDLE, with in_ready = 1 on the next cycle.
REQ-029 The block SHALL hold the flags and digits_used at their last values outside DONE; they are valid only with out_valid.
REQ-030 The block SHALL ignore in_valid outside IDLE, and A and B outside the accept cycle.
REQ-031 With NDIG = 1, the block SHALL always produce its result one cycle after accept.

Reset
REQ-032 When rst_n = 0, the block SHALL immediately enter IDLE and drive in_ready = 1, out_valid = 0, all flags = 0 and digits_used = 0.
REQ-033 The block SHALL clear the shift registers and digit counter to 0 on reset.
REQ-034 Reset during CMP or DONE SHALL abort the operation; no result for the aborted transaction is ever presented.

Verification (WIDTH=32, DIGIT=4)
REQ-035 Unsigned, A=0x8000_0000, B=0x7FFF_FFFF -> A_greater_B=1, digits_used=1, out_valid one cycle after accept.
REQ-036 A=B=0x1234_5678 -> A_equal_B=1, digits_used=8, out_valid 8 cycles after accept.
REQ-037 SIGNED=1, A=0xFFFF_FFFF, B=0x0000_0001 -> A_lesser_B=1, digits_used=1; the same operands with SIGNED=0 -> A_greater_B=1.
REQ-038 A=0x1234_5670, B=0x1234_5679, out_ready low for 3 cycles -> A_lesser_B=1, digits_used=8; outputs stable and in_ready=0 throughout the stall.
REQ-039 rst_n pulsed low 3 cycles after accepting A=B=0xAAAA_AAAA -> out_valid stays 0 with no result; after release in_ready=1; the next pair 5 vs 3 gives A_greater_B=1, digits_used=8.
REQ-040 in_valid and out_ready held at 1 with 4 back-to-back pairs -> each result presented once and in order, in_ready high exactly one cycle after each output handshake.
